// File: rtl/status_decoder.sv
// Recovers the 2-bit status code (off / on / blinking) from the status LED line by run-length classification.
// Optional input glitch filter: define STATUS_DEC_GLITCH_EN.
module status_decoder #(
  parameter int unsigned HALF_PERIOD = 27_000_000,
  parameter int unsigned TOL         = 1_350_000,
  parameter int unsigned TIMEOUT     = 54_000_000,
  parameter int unsigned GLITCH_CYC  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power_in,
  output logic [1:0] status,
  output logic       valid,
  output logic       changed
);

  localparam int unsigned CW      = $clog2(TIMEOUT + 1);
  localparam int unsigned GOOD_LO = HALF_PERIOD - TOL;
  localparam int unsigned GOOD_HI = HALF_PERIOD + TOL;
  localparam logic [CW-1:0] RUN_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] RUN_PRE = CW'(TIMEOUT - 1);

  if (TOL > HALF_PERIOD || TIMEOUT < 2 || GLITCH_CYC < 1) begin : g_param_check
    $error("status_decoder: invalid parameter set");
  end

  typedef enum logic [2:0] {
    UNKNOWN,
    STEADY_LO,
    STEADY_HI,
    BLINK_ACQ,
    BLINK
  } state_t;

  typedef enum logic [1:0] {
    CODE_OFF   = 2'd0,
    CODE_ON    = 2'd1,
    CODE_BLINK = 2'd2
  } code_t;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_pipe <= '0;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n = rst_pipe[1];

  logic [1:0] sync;
  logic       lvl;
  logic       lvl_d;
  logic       lvl_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[0], power_in};
  end

`ifdef STATUS_DEC_GLITCH_EN
  localparam int unsigned GW = $clog2(GLITCH_CYC + 1);
  logic [GW-1:0] stab_cnt;

  // lvl follows the synchronized input only once it has held its new value GLITCH_CYC cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt <= '0;
      lvl      <= 1'b0;
    end else if (sync[1] == lvl) begin
      stab_cnt <= '0;
    end else if (stab_cnt == GW'(GLITCH_CYC - 1)) begin
      stab_cnt <= '0;
      lvl      <= sync[1];
    end else begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end
`else
  assign lvl = sync[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_d <= 1'b0;
    else        lvl_d <= lvl;
  end

  assign lvl_edge = lvl ^ lvl_d;

  logic [CW-1:0] run;
  logic          half_good;
  logic          sat_hit;
  code_t         steady_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               run <= '0;
    else if (lvl_edge)        run <= CW'(1);
    else if (run != RUN_MAX)  run <= run + 1'b1;
  end

  assign half_good   = (32'(run) >= GOOD_LO) && (32'(run) <= GOOD_HI);
  // Fires only on the cycle the counter steps into saturation; an edge that cycle takes priority.
  assign sat_hit     = !lvl_edge && (run == RUN_PRE);
  assign steady_code = lvl ? CODE_ON : CODE_OFF;

  state_t     state;
  logic [1:0] good_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UNKNOWN;
      good_cnt <= '0;
      status   <= CODE_OFF;
      valid    <= 1'b0;
      changed  <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (lvl_edge) begin
        case (state)
          BLINK_ACQ: begin
            if (!half_good) begin
              good_cnt <= '0;
            end else if (good_cnt == 2'd1) begin
              state    <= BLINK;
              good_cnt <= 2'd2;
              status   <= CODE_BLINK;
              valid    <= 1'b1;
              changed  <= (status != CODE_BLINK) || !valid;
            end else begin
              good_cnt <= good_cnt + 2'd1;
            end
          end
          BLINK: begin
            if (!half_good) begin
              state <= UNKNOWN;
              valid <= 1'b0;
            end
          end
          default: begin
            // The half closed by this edge began at an unknown time, so it is never counted.
            state    <= BLINK_ACQ;
            good_cnt <= '0;
          end
        endcase
      end else if (sat_hit) begin
        state   <= lvl ? STEADY_HI : STEADY_LO;
        status  <= steady_code;
        valid   <= 1'b1;
        changed <= (status != steady_code) || !valid;
      end
    end
  end

endmodule

// File: tb/tb_status_decoder.sv
// Directed bench for status_decoder: a queue of expected (status, valid) values is consumed on each changed pulse.
module tb_status_decoder;

  localparam int unsigned HP = 20;
  localparam int unsigned TL = 2;
  localparam int unsigned TO = 60;
  localparam int unsigned GC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       power_in = 1'b0;
  logic [1:0] status;
  logic       valid;
  logic       changed;

  int total = 0;
  int bad = 0;
  int pulse_cnt = 0;

  typedef struct packed {
    logic [1:0] st;
    logic       v;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  status_decoder #(
    .HALF_PERIOD(HP),
    .TOL(TL),
    .TIMEOUT(TO),
    .GLITCH_CYC(GC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .power_in(power_in),
    .status(status),
    .valid(valid),
    .changed(changed)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Every changed pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && changed) begin
      pulse_cnt++;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_changed observed status=%0d valid=%0d expected no pulse", status, valid);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("chg_status", 32'(status), 32'(mon_e.st));
        chk("chg_valid", 32'(valid), 32'(mon_e.v));
      end
    end
  end

  task automatic half(input int n);
    power_in = ~power_in;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_change(input string tag, input int budget, output int lat);
    int start;
    start = pulse_cnt;
    lat = 0;
    while (pulse_cnt == start && lat < budget) begin
      @(posedge clk);
      lat++;
    end
    total++;
    assert (pulse_cnt != start) else begin
      bad++;
      $error("FAIL %s_timeout observed=no pulse in %0d cycles expected=pulse", tag, budget);
    end
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int p0;

    repeat (3) @(negedge clk);
    chk("rst_status", 32'(status), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_changed", 32'(changed), 0);

    exp_q.push_back('{st: 2'd0, v: 1'b1});
    reset = 1'b1;
    wait_change("boot", 100, lat);
    chk_range("boot_lat", lat, 55, 75);
    chk("boot_status", 32'(status), 0);
    chk("boot_valid", 32'(valid), 1);

    p0 = pulse_cnt;
    exp_q.push_back('{st: 2'd1, v: 1'b1});
    power_in = 1'b1;
    wait_change("on", 100, lat);
    chk_range("on_lat", lat, 55, 75);
    chk("on_status", 32'(status), 1);
    chk("on_valid", 32'(valid), 1);
    repeat (30) @(negedge clk);
    chk("on_no_repeat", 32'(pulse_cnt), 32'(p0 + 1));

    p0 = pulse_cnt;
    exp_q.push_back('{st: 2'd2, v: 1'b1});
    repeat (8) half(20);
    chk("blink_status", 32'(status), 2);
    chk("blink_valid", 32'(valid), 1);
    chk("blink_pulses", 32'(pulse_cnt), 32'(p0 + 1));

    for (int i = 0; i < 4; i++) begin
      half(18);
      half(22);
    end
    chk("tol_status", 32'(status), 2);
    chk("tol_valid", 32'(valid), 1);
    chk("tol_pulses", 32'(pulse_cnt), 32'(p0 + 1));

    half(17);
    half(10);
    chk("bad17_valid", 32'(valid), 0);
    chk("bad17_status", 32'(status), 2);
    repeat (10) @(negedge clk);
    exp_q.push_back('{st: 2'd2, v: 1'b1});
    repeat (6) half(20);
    chk("reacq17_qempty", 32'(exp_q.size()), 0);
    chk("reacq17_valid", 32'(valid), 1);

    half(23);
    half(10);
    chk("bad23_valid", 32'(valid), 0);
    chk("bad23_status", 32'(status), 2);
    repeat (10) @(negedge clk);
    exp_q.push_back('{st: 2'd2, v: 1'b1});
    repeat (6) half(20);
    chk("reacq23_qempty", 32'(exp_q.size()), 0);
    chk("reacq23_valid", 32'(valid), 1);

    exp_q.push_back('{st: 2'd0, v: 1'b1});
    power_in = 1'b0;
    wait_change("stop", 100, lat);
    chk_range("stop_lat", lat, 55, 75);
    chk("stop_status", 32'(status), 0);
    chk("stop_valid", 32'(valid), 1);

    exp_q.push_back('{st: 2'd2, v: 1'b1});
    repeat (6) half(20);
    chk("mid_status", 32'(status), 2);
    chk("mid_qempty", 32'(exp_q.size()), 0);
    repeat (7) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_status", 32'(status), 0);
    chk("rst_mid_valid", 32'(valid), 0);
    chk("rst_mid_changed", 32'(changed), 0);

    power_in = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.push_back('{st: 2'd0, v: 1'b1});
    reset = 1'b1;
    wait_change("reboot", 100, lat);
    chk_range("reboot_lat", lat, 55, 75);
    chk("reboot_status", 32'(status), 0);
    chk("reboot_valid", 32'(valid), 1);

`ifdef STATUS_DEC_GLITCH_EN
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      power_in = 1'b1;
      repeat (2) @(negedge clk);
      power_in = 1'b0;
      repeat (10) @(negedge clk);
    end
    repeat (70) @(negedge clk);
    chk("glitch_pulses", 32'(pulse_cnt), 32'(p0));
    chk("glitch_status", 32'(status), 0);
    chk("glitch_valid", 32'(valid), 1);
`endif

    chk("final_qempty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
